// File: rtl/weight_sched_pkg.sv
// Shared types and constants for the weight_cut batch sequencer.
// Optional watchdog feature is selected with the WEIGHT_SCHED_WATCHDOG_EN macro.
package weight_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_STR,
      ISSUE,
      WAIT_W,
      COMPUTE,
      NEXT
   } sched_state_t;

   // Integer ceiling division, used to size the per-string batch limit.
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // COMPUTE phase timeout: four string lengths worth of cycles.
   function automatic int wd_limit(input int str_len);
      return 4 * str_len;
   endfunction

   localparam int DEF_DWIDTH     = 8;
   localparam int DEF_NUM        = 4;
   localparam int DEF_GROUPS     = 4;
   localparam int DEF_WEIGHT_NUM = 23331;
   localparam int DEF_STRLEN     = 150;
   localparam int DEF_CNT_W      = 16;

   localparam int MAX_BATCH = ceil_div(DEF_WEIGHT_NUM, DEF_NUM * DEF_GROUPS);
   localparam int WD_LIMIT  = wd_limit(DEF_STRLEN);

endpackage

// File: rtl/weight_sched_ctrl_if.sv
// Bundle of all control/status signals between the sequencer and its
// surroundings (string buffer, matching lanes, weight_cut).
// Handshake: weight_cut answers a one-cycle request pulse on
// signal_from_controller[num] with weight_enable (bus valid) or string_finish;
// lanes report pe_ready as a level and pe_done as a one-cycle pulse; the
// controller answers with one-cycle lane_load and string_ack strobes.
interface weight_sched_ctrl_if #(
   parameter int num   = 4,
   parameter int CNT_W = 16
);
   logic             enable;
   logic             string_ready;
   logic [num-1:0]   pe_ready;
   logic [num-1:0]   pe_done;
   logic             weight_enable;
   logic             string_finish;
   logic [num:0]     signal_from_controller;
   logic [num-1:0]   lane_load;
   logic             string_ack;
   logic [CNT_W-1:0] batch_cnt;
   logic [CNT_W-1:0] string_cnt;
   logic             busy;
   logic             err;

   modport master (
      input  enable, string_ready, pe_ready, pe_done, weight_enable, string_finish,
      output signal_from_controller, lane_load, string_ack, batch_cnt, string_cnt,
             busy, err
   );

   modport slave (
      output enable, string_ready, pe_ready, pe_done, weight_enable, string_finish,
      input  signal_from_controller, lane_load, string_ack, batch_cnt, string_cnt,
             busy, err
   );
endinterface

// File: rtl/lane_done_tracker.sv
// Sticky record of which granted lanes have reported pe_done for the
// current batch. Pulses on ungranted lanes never enter the mask.
module lane_done_tracker #(
   parameter int num = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clear,
   input  logic [num-1:0] grant,
   input  logic [num-1:0] pe_done,
   output logic           all_done,
   output logic [num-1:0] done_mask
);
   logic [num-1:0] mask;

   // Include this cycle's pulses so the batch can close without an extra cycle.
   assign done_mask = mask | (pe_done & grant);
   assign all_done  = ((done_mask & grant) == grant);

   // Accumulate granted completions until the controller clears the mask.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask <= '0;
      end else if (clear) begin
         mask <= '0;
      end else begin
         mask <= done_mask;
      end
   end
endmodule

// File: rtl/weight_sched_ctrl.sv
// Batch sequencer for weight_cut: waits for a string, requests one batch of
// num*groups weights at a time, strobes the granted lanes to latch it and
// waits for every granted lane to finish before the next request.
// Define WEIGHT_SCHED_WATCHDOG_EN to add a COMPUTE timeout that drops
// unresponsive lanes for the rest of the string.
module weight_sched_ctrl
   import weight_sched_pkg::*;
#(
   parameter int DWIDTH     = DEF_DWIDTH,
   parameter int num        = DEF_NUM,
   parameter int groups     = DEF_GROUPS,
   parameter int weight_num = DEF_WEIGHT_NUM,
   parameter int strlen     = DEF_STRLEN,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                reset,
   weight_sched_ctrl_if.master bus,
   output sched_state_t        fsm_state
);
   localparam int               MAX_B    = ceil_div(weight_num, num * groups);
   localparam logic [CNT_W-1:0] MAX_B_C  = CNT_W'(MAX_B);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   sched_state_t   state;
   logic [num-1:0] grant;
   logic [num-1:0] drop;
   logic [num-1:0] avail;
   logic [num-1:0] done_mask;
   logic           all_done;
   logic           done_clear;
   logic           wd_expire;

   assign fsm_state  = state;
   assign avail      = bus.pe_ready & ~drop;
   assign done_clear = (state != COMPUTE) || all_done || wd_expire;

   lane_done_tracker #(.num(num)) u_done (
      .clk       (clk),
      .reset     (reset),
      .clear     (done_clear),
      .grant     (grant),
      .pe_done   (bus.pe_done),
      .all_done  (all_done),
      .done_mask (done_mask)
   );

`ifdef WEIGHT_SCHED_WATCHDOG_EN
   localparam int WD_LIM = wd_limit(strlen);
   localparam int WD_W   = $clog2(WD_LIM + 1);

   logic [WD_W-1:0] wd_cnt;

   // Count cycles spent in COMPUTE, restarting from zero on every entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt <= '0;
      end else if (state == COMPUTE) begin
         wd_cnt <= wd_cnt + 1'b1;
      end else begin
         wd_cnt <= '0;
      end
   end

   assign wd_expire = (state == COMPUTE) && !all_done && (wd_cnt == WD_W'(WD_LIM - 1));
`else
   assign wd_expire = 1'b0;
   assign drop      = '0;
`endif

   // Main sequencer: state, grant, counters and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                      <= IDLE;
         grant                      <= '0;
         bus.signal_from_controller <= '0;
         bus.lane_load              <= '0;
         bus.string_ack             <= 1'b0;
         bus.batch_cnt              <= '0;
         bus.string_cnt             <= '0;
         bus.busy                   <= 1'b0;
         bus.err                    <= 1'b0;
`ifdef WEIGHT_SCHED_WATCHDOG_EN
         drop                       <= '0;
`endif
      end else begin
         // Strobes default low so every pulse lasts exactly one cycle.
         bus.signal_from_controller <= '0;
         bus.lane_load              <= '0;
         bus.string_ack             <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.enable) begin
                  state    <= WAIT_STR;
                  bus.busy <= 1'b1;
               end
            end
            WAIT_STR: begin
               if (bus.string_ready) begin
                  state <= ISSUE;
               end else if (!bus.enable) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            ISSUE: begin
               if (!bus.enable) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else if (bus.batch_cnt >= MAX_B_C) begin
                  // weight_cut never reported the end of the string: close it here.
                  bus.err <= 1'b1;
                  state   <= NEXT;
               end else if (|avail) begin
                  grant                      <= avail;
                  bus.signal_from_controller <= {1'b1, ~avail};
                  state                      <= WAIT_W;
               end
            end
            WAIT_W: begin
               if (bus.string_finish) begin
                  state <= NEXT;
               end else if (bus.weight_enable) begin
                  bus.lane_load <= grant;
                  if (bus.batch_cnt != CNT_SAT) begin
                     bus.batch_cnt <= bus.batch_cnt + 1'b1;
                  end
                  state <= COMPUTE;
               end
            end
            COMPUTE: begin
               if (all_done) begin
                  state <= ISSUE;
               end
`ifdef WEIGHT_SCHED_WATCHDOG_EN
               else if (wd_expire) begin
                  bus.err <= 1'b1;
                  drop    <= drop | (grant & ~done_mask);
                  state   <= ISSUE;
               end
`endif
            end
            NEXT: begin
               bus.string_ack <= 1'b1;
               bus.string_cnt <= bus.string_cnt + 1'b1;
               bus.batch_cnt  <= '0;
`ifdef WEIGHT_SCHED_WATCHDOG_EN
               drop           <= '0;
`endif
               state          <= WAIT_STR;
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_weight_sched_ctrl.sv
// Directed-plus-random bench for weight_sched_ctrl. Expected requests are
// derived from lane readiness (request bit plus inverted ready mask) and
// queued; counters and flags are tracked as plain integers.
module tb_weight_sched_ctrl;
   import weight_sched_pkg::*;

   localparam int NUM     = 4;
   localparam int CW      = 16;
   localparam int REF_MAX = (23331 + NUM * 4 - 1) / (NUM * 4);

   logic         clk = 1'b0;
   logic         reset;
   sched_state_t fsm_state;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_batch = 0;
   int exp_strings = 0;
   logic [NUM:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   weight_sched_ctrl_if #(.num(NUM), .CNT_W(CW)) bus ();

   weight_sched_ctrl #(
      .DWIDTH(8), .num(NUM), .groups(4), .weight_num(23331), .strlen(150), .CNT_W(CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_sfc"},  32'(bus.signal_from_controller), 0);
      chk({tag, "_load"}, 32'(bus.lane_load), 0);
      chk({tag, "_ack"},  32'(bus.string_ack), 0);
      chk({tag, "_bcnt"}, 32'(bus.batch_cnt), 0);
      chk({tag, "_scnt"}, 32'(bus.string_cnt), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_err"},  32'(bus.err), 0);
   endtask

   // Wait (bounded) for the next request and compare it with the queue head.
   task automatic expect_req(input string tag);
      bit got;
      logic [NUM:0] e;
      got = 1'b0;
      e = exp_q.pop_front();
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (bus.signal_from_controller[NUM]) got = 1'b1;
      end
      chk({tag, "_seen"}, 32'(got), 1);
      if (got) begin
         chk({tag, "_val"}, 32'(bus.signal_from_controller), 32'(e));
         tick();
         chk({tag, "_one_cycle"}, 32'(bus.signal_from_controller), 0);
      end
   endtask

   task automatic watch_no_req(input string tag, input int n);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.signal_from_controller[NUM]) seen = 1'b1;
      end
      chk(tag, 32'(seen), 0);
   endtask

   // ---------------- drivers ----------------
   task automatic load(input logic [NUM-1:0] g);
      bus.weight_enable = 1'b1;
      tick();
      bus.weight_enable = 1'b0;
      if (exp_batch < 65535) exp_batch++;
      chk("lane_load", 32'(bus.lane_load), 32'(g));
      chk("batch_cnt", 32'(bus.batch_cnt), 32'(exp_batch));
      tick();
      chk("lane_load_end", 32'(bus.lane_load), 0);
   endtask

   task automatic pulse_done(input logic [NUM-1:0] m);
      bus.pe_done = m;
      tick();
      bus.pe_done = '0;
   endtask

   // Report granted lanes one by one in random order, sprinkling pulses on
   // ungranted lanes; the next request may only follow the last granted lane.
   task automatic finish_batch(input logic [NUM-1:0] g, input logic [NUM-1:0] next_pr);
      int order[$];
      bit early;
      early = 1'b0;
      for (int i = 0; i < NUM; i++) if (g[i]) order.push_back(i);
      for (int i = order.size() - 1; i > 0; i--) begin
         int j;
         int t;
         j = int'($urandom_range(0, i));
         t = order[i];
         order[i] = order[j];
         order[j] = t;
      end
      for (int k = 0; k < order.size(); k++) begin
         logic [NUM-1:0] m;
         m = NUM'(1 << order[k]);
         if (k == order.size() - 1) begin
            bus.pe_ready = next_pr;
            exp_q.push_back({1'b1, ~next_pr});
         end else if ($urandom_range(0, 1) == 1) begin
            m = m | (~g & NUM'($urandom));
         end
         pulse_done(m);
         if (k != order.size() - 1) begin
            tick();
            if (bus.signal_from_controller[NUM]) early = 1'b1;
         end
      end
      chk("no_early_req", 32'(early), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [NUM-1:0] cur;
      logic [NUM-1:0] nxt;
      bit ack_seen;
      bit req_seen;

      reset = 1'b1;
      bus.enable = 1'b0;
      bus.string_ready = 1'b0;
      bus.pe_ready = '0;
      bus.pe_done = '0;
      bus.weight_enable = 1'b0;
      bus.string_finish = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;

      // First batch: request two cycles after the string is seen in WAIT_STR.
      bus.enable = 1'b1;
      bus.string_ready = 1'b1;
      bus.pe_ready = 4'b1111;
      tick();
      chk("busy_on", 32'(bus.busy), 1);
      chk("lat_c1", 32'(bus.signal_from_controller), 0);
      tick();
      chk("lat_c2", 32'(bus.signal_from_controller), 0);
      tick();
      chk("first_req", 32'(bus.signal_from_controller), 32'(5'b10000));
      tick();
      chk("first_req_end", 32'(bus.signal_from_controller), 0);
      load(4'b1111);

      // Partial grant: lanes 0 and 2 only.
      bus.pe_ready = 4'b0101;
      exp_q.push_back({1'b1, ~4'b0101});
      pulse_done(4'b1111);
      expect_req("req_0101");
      load(4'b0101);
      pulse_done(4'b0001);
      watch_no_req("wait_lane2", 3);
      pulse_done(4'b0010);
      watch_no_req("ignore_lane1", 3);
      bus.pe_ready = 4'b0000;
      pulse_done(4'b0100);
      watch_no_req("stall_no_ready", 4);
      chk("busy_stall", 32'(bus.busy), 1);
      cur = 4'($urandom_range(1, 15));
      bus.pe_ready = cur;
      exp_q.push_back({1'b1, ~cur});
      expect_req("req_after_stall");

      // Random batches.
      for (int b = 0; b < 6; b++) begin
         load(cur);
         nxt = 4'($urandom_range(1, 15));
         finish_batch(cur, nxt);
         expect_req("req_rand");
         cur = nxt;
      end

      // weight_enable and string_finish together: finish wins, no load.
      bus.weight_enable = 1'b1;
      bus.string_finish = 1'b1;
      tick();
      bus.weight_enable = 1'b0;
      bus.string_finish = 1'b0;
      chk("fin_no_load", 32'(bus.lane_load), 0);
      tick();
      exp_strings++;
      exp_batch = 0;
      chk("fin_ack", 32'(bus.string_ack), 1);
      chk("fin_scnt", 32'(bus.string_cnt), 32'(exp_strings));
      chk("fin_bcnt", 32'(bus.batch_cnt), 0);
      bus.string_ready = 1'b0;
      tick();
      chk("fin_ack_end", 32'(bus.string_ack), 0);
      watch_no_req("no_str_no_req", 4);

      // Overflow: a string that never reports string_finish.
      bus.string_ready = 1'b1;
      bus.pe_ready = 4'b1111;
      exp_q.push_back(5'b10000);
      expect_req("ovf_first");
      for (int b = 1; b <= REF_MAX; b++) begin
         if (b == REF_MAX) chk("ovf_err_before", 32'(bus.err), 0);
         load(4'b1111);
         if (b < REF_MAX) begin
            exp_q.push_back(5'b10000);
            pulse_done(4'b1111);
            expect_req("ovf_req");
         end else begin
            pulse_done(4'b1111);
         end
      end
      ack_seen = 1'b0;
      req_seen = 1'b0;
      for (int i = 0; i < 10 && !ack_seen; i++) begin
         tick();
         if (bus.signal_from_controller[NUM]) req_seen = 1'b1;
         if (bus.string_ack) begin
            ack_seen = 1'b1;
            bus.string_ready = 1'b0;
         end
      end
      exp_strings++;
      exp_batch = 0;
      chk("ovf_ack", 32'(ack_seen), 1);
      chk("ovf_no_extra_req", 32'(req_seen), 0);
      chk("ovf_err", 32'(bus.err), 1);
      chk("ovf_scnt", 32'(bus.string_cnt), 32'(exp_strings));
      chk("ovf_bcnt", 32'(bus.batch_cnt), 0);

      // Reset while lane_load is being strobed in COMPUTE.
      bus.string_ready = 1'b1;
      exp_q.push_back(5'b10000);
      expect_req("pre_reset_req");
      bus.weight_enable = 1'b1;
      tick();
      bus.weight_enable = 1'b0;
      chk("pending_load", 32'(bus.lane_load), 32'(4'b1111));
      #2;
      reset = 1'b1;
      bus.enable = 1'b0;
      bus.string_ready = 1'b0;
      #1;
      check_all_zero("mid_reset");
      tick();
      reset = 1'b0;
      exp_batch = 0;
      exp_strings = 0;
      watch_no_req("post_reset_idle", 5);
      chk("post_reset_busy", 32'(bus.busy), 0);
      bus.enable = 1'b1;
      watch_no_req("post_reset_no_str", 4);
      bus.string_ready = 1'b1;
      exp_q.push_back(5'b10000);
      expect_req("post_reset_req");
      load(4'b1111);

`ifdef WEIGHT_SCHED_WATCHDOG_EN
      begin
         int cycles;
         bit got;
         cycles = 0;
         got = 1'b0;
         pulse_done(4'b0111);
         for (int i = 0; i < 700 && !got; i++) begin
            tick();
            cycles++;
            if (bus.signal_from_controller[NUM]) got = 1'b1;
         end
         chk("wd_req_seen", 32'(got), 1);
         chk("wd_err", 32'(bus.err), 1);
         chk("wd_skip_lane3", 32'(bus.signal_from_controller), 32'(5'b11000));
         chk("wd_long_wait", 32'(cycles >= 580), 1);
      end
`else
      exp_q.push_back(5'b10000);
      pulse_done(4'b1111);
      expect_req("tail_req");
      chk("tail_err", 32'(bus.err), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
